// File: rtl/ex_stage_pkg.sv
// Shared widths and ALU operation bit positions for the EX stage.
package ex_stage_pkg;
  localparam int unsigned ID2EX_BUS_W = 151;
  localparam int unsigned EX2MA_BUS_W = 71;
  localparam int unsigned ALU_OP_W    = 12;

  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_SUB   = 1;
  localparam int unsigned OP_SLT   = 2;
  localparam int unsigned OP_SLTU  = 3;
  localparam int unsigned OP_AND   = 4;
  localparam int unsigned OP_NOR   = 5;
  localparam int unsigned OP_OR    = 6;
  localparam int unsigned OP_XOR   = 7;
  localparam int unsigned OP_SLL   = 8;
  localparam int unsigned OP_SRL   = 9;
  localparam int unsigned OP_SRA   = 10;
  localparam int unsigned OP_LU12I = 11;
endpackage

// File: rtl/ex_stage_alu.sv
// 32-bit combinational ALU selected by a one-hot operation vector.
module alu
  import ex_stage_pkg::*;
(
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [31:0]         alu_src1,
  input  logic [31:0]         alu_src2,
  output logic [31:0]         alu_result
);
  logic [4:0] sa;
  logic       slt_bit;
  logic       sltu_bit;

  assign sa       = alu_src2[4:0];
  assign slt_bit  = $signed(alu_src1) < $signed(alu_src2);
  assign sltu_bit = alu_src1 < alu_src2;

  // And-or merge: an all-zero op vector yields zero.
  always_comb begin
    alu_result = '0;
    if (alu_op[OP_ADD])   alu_result |= alu_src1 + alu_src2;
    if (alu_op[OP_SUB])   alu_result |= alu_src1 - alu_src2;
    if (alu_op[OP_SLT])   alu_result |= {31'b0, slt_bit};
    if (alu_op[OP_SLTU])  alu_result |= {31'b0, sltu_bit};
    if (alu_op[OP_AND])   alu_result |= alu_src1 & alu_src2;
    if (alu_op[OP_NOR])   alu_result |= ~(alu_src1 | alu_src2);
    if (alu_op[OP_OR])    alu_result |= alu_src1 | alu_src2;
    if (alu_op[OP_XOR])   alu_result |= alu_src1 ^ alu_src2;
    if (alu_op[OP_SLL])   alu_result |= alu_src1 << sa;
    if (alu_op[OP_SRL])   alu_result |= alu_src1 >> sa;
    if (alu_op[OP_SRA])   alu_result |= 32'($signed(alu_src1) >>> sa);
    if (alu_op[OP_LU12I]) alu_result |= alu_src2;
  end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: holds one decoded bundle, evaluates the ALU and issues the data-SRAM request.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_validout,
  input  logic                   ma_allowin,
  output logic                   ex_allowin,
  output logic                   ex_validout,
  input  logic [ID2EX_BUS_W-1:0] id_to_ex_bus,
  output logic [EX2MA_BUS_W-1:0] ex_to_ma_bus,
  output logic [4:0]             ex_to_id_dest,
  output logic                   data_sram_en,
  output logic [3:0]             data_sram_we,
  output logic [31:0]            data_sram_addr,
  output logic [31:0]            data_sram_wdata
);
  logic                   valid;
  logic [ID2EX_BUS_W-1:0] bundle;

  logic [ALU_OP_W-1:0] alu_op;
  logic                load_op;
  logic                src1_is_pc;
  logic                src2_is_imm;
  logic                gr_we;
  logic                mem_we;
  logic [4:0]          dest;
  logic [31:0]         imm;
  logic [31:0]         rj_value;
  logic [31:0]         rkd_value;
  logic [31:0]         pc;
  logic                res_from_mem;
  logic                unused_load_op;

  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;
  logic        req;

  assign {alu_op, load_op, src1_is_pc, src2_is_imm, gr_we, mem_we, dest,
          imm, rj_value, rkd_value, pc, res_from_mem} = bundle;
  assign unused_load_op = load_op;

  assign ex_allowin  = ~valid | ma_allowin;
  assign ex_validout = valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      bundle <= '0;
    end else begin
      if (ex_allowin) valid <= id_validout;
      if (id_validout && ex_allowin) bundle <= id_to_ex_bus;
    end
  end

  assign alu_src1 = src1_is_pc  ? pc  : rj_value;
  assign alu_src2 = src2_is_imm ? imm : rkd_value;

  alu u_alu (
    .alu_op     (alu_op),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_result (alu_result)
  );

  // Request only on the hand-off cycle; masked by rst so a held bundle cannot fire during reset.
  assign req             = valid & ma_allowin & ~rst & (res_from_mem | mem_we);
  assign data_sram_en    = req;
  assign data_sram_we    = {4{req & mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rkd_value;

  assign ex_to_id_dest = (valid & gr_we) ? dest : 5'd0;
  assign ex_to_ma_bus  = {res_from_mem, gr_we, dest, alu_result, pc};
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: per-cycle reference model plus directed literal checks.
module tb_ex_stage;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         id_validout = 1'b0;
  logic         ma_allowin = 1'b1;
  logic [150:0] id_to_ex_bus = '0;
  logic         ex_allowin, ex_validout;
  logic [70:0]  ex_to_ma_bus;
  logic [4:0]   ex_to_id_dest;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .id_validout(id_validout), .ma_allowin(ma_allowin),
    .ex_allowin(ex_allowin), .ex_validout(ex_validout), .id_to_ex_bus(id_to_ex_bus),
    .ex_to_ma_bus(ex_to_ma_bus), .ex_to_id_dest(ex_to_id_dest),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
  );

  typedef struct {
    logic [11:0] op;
    logic        s1pc, s2imm, gr_we, mem_we, rfm;
    logic [4:0]  dest;
    logic [31:0] imm, rj, rkd, pc;
  } instr_t;

  function automatic instr_t mk(logic [11:0] op, logic s1pc, logic s2imm, logic gr_we,
                                logic mem_we, logic rfm, logic [4:0] dest, logic [31:0] imm,
                                logic [31:0] rj, logic [31:0] rkd, logic [31:0] pc);
    instr_t i;
    i.op = op; i.s1pc = s1pc; i.s2imm = s2imm; i.gr_we = gr_we; i.mem_we = mem_we;
    i.rfm = rfm; i.dest = dest; i.imm = imm; i.rj = rj; i.rkd = rkd; i.pc = pc;
    return i;
  endfunction

  function automatic logic [150:0] pack(instr_t i);
    return {i.op, i.rfm, i.s1pc, i.s2imm, i.gr_we, i.mem_we, i.dest, i.imm, i.rj, i.rkd, i.pc, i.rfm};
  endfunction

  function automatic logic [31:0] model_alu(logic [11:0] op, logic [31:0] a, logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if (op[0])  return a + b;
    if (op[1])  return a - b;
    if (op[2])  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    if (op[3])  return (a < b) ? 32'd1 : 32'd0;
    if (op[4])  return a & b;
    if (op[5])  return ~(a | b);
    if (op[6])  return a | b;
    if (op[7])  return a ^ b;
    if (op[8])  return a << sh;
    if (op[9])  return a >> sh;
    if (op[10]) return 32'($signed(a) >>> sh);
    if (op[11]) return b;
    return 32'd0;
  endfunction

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one held instruction plus its valid bit.
  instr_t cur_in;
  instr_t m_ins;
  logic   m_valid = 1'b0;
  logic   started = 1'b0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_valid <= 1'b0;
      m_ins   <= mk('0, 0, 0, 0, 0, 0, '0, '0, '0, '0, '0);
    end else if (!m_valid || ma_allowin) begin
      m_valid <= id_validout;
      if (id_validout) m_ins <= cur_in;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [31:0] res;
      logic        req;
      res = model_alu(m_ins.op, m_ins.s1pc ? m_ins.pc : m_ins.rj, m_ins.s2imm ? m_ins.imm : m_ins.rkd);
      req = m_valid && ma_allowin && !rst && (m_ins.rfm || m_ins.mem_we);
      chk("model_allowin", 71'(ex_allowin), 71'(!m_valid || ma_allowin));
      chk("model_validout", 71'(ex_validout), 71'(m_valid));
      chk("model_dest", 71'(ex_to_id_dest), 71'((m_valid && m_ins.gr_we) ? m_ins.dest : 5'd0));
      chk("model_en", 71'(data_sram_en), 71'(req));
      chk("model_we", 71'(data_sram_we), 71'((req && m_ins.mem_we) ? 4'hF : 4'h0));
      chk("model_addr", 71'(data_sram_addr), 71'(res));
      chk("model_wdata", 71'(data_sram_wdata), 71'(m_ins.rkd));
      chk("model_mabus", ex_to_ma_bus, {m_ins.rfm, m_ins.gr_we, m_ins.dest, res, m_ins.pc});
    end
  end

  // Offer one bundle for exactly one clock edge; returns just after that edge.
  task automatic issue(input instr_t i);
    cur_in       = i;
    id_to_ex_bus = pack(i);
    id_validout  = 1'b1;
    @(posedge clk); #1;
    id_validout  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  instr_t alu_vec[$];
  logic [31:0] alu_exp[$];

  initial begin
    cur_in = mk('0, 0, 0, 0, 0, 0, '0, '0, '0, '0, '0);
    tick(); tick();
    @(negedge clk);
    chk("rst_allowin", 71'(ex_allowin), 71'(1));
    chk("rst_validout", 71'(ex_validout), 71'(0));
    chk("rst_en", 71'(data_sram_en), 71'(0));
    chk("rst_mabus", ex_to_ma_bus, 71'(0));
    tick();
    rst = 1'b0;

    // add.w r3 = 5 + 7
    issue(mk(12'h001, 0, 0, 1, 0, 0, 5'd3, 32'd0, 32'd5, 32'd7, 32'h1C000010));
    @(negedge clk);
    chk("add_valid", 71'(ex_validout), 71'(1));
    chk("add_result", 71'(data_sram_addr), 71'(32'd12));
    chk("add_dest", 71'(ex_to_id_dest), 71'(3));
    chk("add_en", 71'(data_sram_en), 71'(0));
    tick();

    // st.w: addr 0x1000+8, one-cycle request
    issue(mk(12'h001, 0, 1, 0, 1, 0, 5'd9, 32'd8, 32'h1000, 32'hDEADBEEF, 32'h1C000014));
    @(negedge clk);
    chk("st_en", 71'(data_sram_en), 71'(1));
    chk("st_we", 71'(data_sram_we), 71'(4'hF));
    chk("st_addr", 71'(data_sram_addr), 71'(32'h1008));
    chk("st_wdata", 71'(data_sram_wdata), 71'(32'hDEADBEEF));
    chk("st_dest", 71'(ex_to_id_dest), 71'(0));
    tick();
    @(negedge clk);
    chk("st_en_once", 71'(data_sram_en), 71'(0));
    tick();

    // ld.w stalled by MA for 3 cycles
    ma_allowin = 1'b0;
    issue(mk(12'h001, 0, 1, 1, 0, 1, 5'd4, 32'd4, 32'h2000, 32'h0, 32'h1C000018));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ld_stall_allowin", 71'(ex_allowin), 71'(0));
      chk("ld_stall_en", 71'(data_sram_en), 71'(0));
      chk("ld_stall_bus", ex_to_ma_bus, {1'b1, 1'b1, 5'd4, 32'h2004, 32'h1C000018});
      tick();
    end
    ma_allowin = 1'b1;
    @(negedge clk);
    chk("ld_rel_en", 71'(data_sram_en), 71'(1));
    chk("ld_rel_we", 71'(data_sram_we), 71'(0));
    tick();
    @(negedge clk);
    chk("ld_en_once", 71'(data_sram_en), 71'(0));
    tick();

    // ALU corners and each op, issued back to back
    alu_vec.push_back(mk(12'h004, 0, 0, 1, 0, 0, 5'd1, 0, 32'hFFFFFFFF, 32'd1, 0)); alu_exp.push_back(32'd1);
    alu_vec.push_back(mk(12'h008, 0, 0, 1, 0, 0, 5'd1, 0, 32'hFFFFFFFF, 32'd1, 0)); alu_exp.push_back(32'd0);
    alu_vec.push_back(mk(12'h400, 0, 0, 1, 0, 0, 5'd1, 0, 32'h80000000, 32'd31, 0)); alu_exp.push_back(32'hFFFFFFFF);
    alu_vec.push_back(mk(12'h001, 0, 0, 1, 0, 0, 5'd1, 0, 32'hFFFFFFFF, 32'd1, 0)); alu_exp.push_back(32'd0);
    alu_vec.push_back(mk(12'h800, 0, 1, 1, 0, 0, 5'd1, 32'h12345000, 0, 0, 0)); alu_exp.push_back(32'h12345000);
    alu_vec.push_back(mk(12'h001, 1, 1, 1, 0, 0, 5'd1, 32'd4, 0, 0, 32'h1C000000)); alu_exp.push_back(32'h1C000004);
    alu_vec.push_back(mk(12'h002, 0, 0, 1, 0, 0, 5'd1, 0, 32'h12345678, 32'hF, 0)); alu_exp.push_back(32'h12345669);
    alu_vec.push_back(mk(12'h010, 0, 0, 1, 0, 0, 5'd1, 0, 32'h12345678, 32'hF, 0)); alu_exp.push_back(32'h00000008);
    alu_vec.push_back(mk(12'h020, 0, 0, 1, 0, 0, 5'd1, 0, 32'h12345678, 32'hF, 0)); alu_exp.push_back(32'hEDCBA980);
    alu_vec.push_back(mk(12'h040, 0, 0, 1, 0, 0, 5'd1, 0, 32'h12345678, 32'hF, 0)); alu_exp.push_back(32'h1234567F);
    alu_vec.push_back(mk(12'h080, 0, 0, 1, 0, 0, 5'd1, 0, 32'h12345678, 32'hF, 0)); alu_exp.push_back(32'h12345677);
    alu_vec.push_back(mk(12'h100, 0, 0, 1, 0, 0, 5'd1, 0, 32'h12345678, 32'hF, 0)); alu_exp.push_back(32'h2B3C0000);
    alu_vec.push_back(mk(12'h200, 0, 0, 1, 0, 0, 5'd1, 0, 32'h12345678, 32'hF, 0)); alu_exp.push_back(32'h00002468);
    alu_vec.push_back(mk(12'h000, 0, 0, 1, 0, 0, 5'd1, 0, 32'h12345678, 32'hF, 0)); alu_exp.push_back(32'h0);
    foreach (alu_vec[k]) begin
      issue(alu_vec[k]);
      @(negedge clk);
      chk($sformatf("alu_vec%0d", k), 71'(data_sram_addr), 71'(alu_exp[k]));
    end
    tick();

    // four back-to-back instructions, then a bubble
    for (int k = 0; k < 4; k++) begin
      issue(mk(12'h001, 0, 1, 1, 0, 0, 5'(k + 10), 32'(k), 32'd100, 0, 32'(k * 4)));
      @(negedge clk);
      chk("b2b_valid", 71'(ex_validout), 71'(1));
      chk("b2b_dest", 71'(ex_to_id_dest), 71'(k + 10));
    end
    tick();
    @(negedge clk);
    chk("b2b_bubble_valid", 71'(ex_validout), 71'(0));
    chk("b2b_bubble_dest", 71'(ex_to_id_dest), 71'(0));
    tick();

    // reset while a stalled st.w is held; MA opens during the reset cycle
    ma_allowin = 1'b0;
    issue(mk(12'h001, 0, 1, 1, 1, 0, 5'd7, 32'd0, 32'h3000, 32'h55AA55AA, 32'h1C000040));
    @(negedge clk);
    chk("rst6_held_dest", 71'(ex_to_id_dest), 71'(7));
    tick();
    rst = 1'b1;
    ma_allowin = 1'b1;
    @(negedge clk);
    chk("rst6_cycle_en", 71'(data_sram_en), 71'(0));
    tick();
    rst = 1'b0;
    ma_allowin = 1'b0;
    @(negedge clk);
    chk("rst6_valid", 71'(ex_validout), 71'(0));
    chk("rst6_en", 71'(data_sram_en), 71'(0));
    chk("rst6_dest", 71'(ex_to_id_dest), 71'(0));
    chk("rst6_allowin", 71'(ex_allowin), 71'(1));
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
